// File: rtl/exp_seq_pkg.sv
// Shared definitions for the FPU exponent sequencer.
// Op encodings, FSM state encoding and exponent register-file select codes.
// Pure declarations; no timing or flow-control behaviour.
package exp_seq_pkg;

  localparam int EXP_W = 9;

  // Operation encodings carried on op_in; 101..111 are illegal.
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_DIV    = 3'b001;
  localparam logic [2:0] OP_SUB    = 3'b010;
  localparam logic [2:0] OP_INT2FP = 3'b011;
  localparam logic [2:0] OP_INC    = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_S1   = 3'd2,
    ST_S2   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Register-file read selects: two GPRs followed by six constants.
  localparam logic [2:0] SEL_R0    = 3'b000;
  localparam logic [2:0] SEL_R1    = 3'b001;
  localparam logic [2:0] SEL_ZERO  = 3'b010;
  localparam logic [2:0] SEL_ONE   = 3'b011;
  localparam logic [2:0] SEL_RADIX = 3'b100;
  localparam logic [2:0] SEL_I2F   = 3'b101;
  localparam logic [2:0] SEL_BIAS  = 3'b110;
  localparam logic [2:0] SEL_ONES  = 3'b111;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_INC;
  endfunction

  // MUL and DIV need a second step to re-apply the exponent bias.
  function automatic logic op_two_step(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/exp_sequencer_if.sv
// Command/result interface between FPU control and the exponent sequencer.
// No latency of its own; plain wires.
// Handshake is start_in/ready_out; results are held until the next done.
interface exp_sequencer_if #(
  parameter int EXP_WIDTH = 9
);
  logic                 start_in;
  logic [2:0]           op_in;
  logic [EXP_WIDTH-1:0] expA_in;
  logic [EXP_WIDTH-1:0] expB_in;
  logic                 ready_out;
  logic                 done_out;
  logic                 err_out;
  logic [EXP_WIDTH-1:0] result_out;
  logic                 neg_out;
  logic                 zero_out;

  // FPU control side issues commands and consumes results.
  modport master (
    output start_in, op_in, expA_in, expB_in,
    input  ready_out, done_out, err_out, result_out, neg_out, zero_out
  );

  // Sequencer side accepts commands and reports results.
  modport slave (
    input  start_in, op_in, expA_in, expB_in,
    output ready_out, done_out, err_out, result_out, neg_out, zero_out
  );
endinterface

// File: rtl/exp_alu.sv
// Combinational add/subtract for the exponent path, modulo 2^EXP_WIDTH.
// Zero latency.
// No flow control.
module exp_alu #(
  parameter int EXP_WIDTH = 9
) (
  input  logic [EXP_WIDTH-1:0] a_i,
  input  logic [EXP_WIDTH-1:0] b_i,
  input  logic                 sub_i,
  output logic [EXP_WIDTH-1:0] res_o
);
  // Wraparound is intentional: overflow/underflow shows up in the top bit.
  assign res_o = sub_i ? (a_i - b_i) : (a_i + b_i);
endmodule

// File: rtl/exp_sequencer.sv
// Microcoded exponent controller: LOAD operands, run 1-2 ALU steps, report.
// Done 3 cycles after accept (SUB/INT2FP/INC), 4 (MUL/DIV), 1 (illegal op).
// One command in flight; start_in while busy is ignored, never queued.
module exp_sequencer
  import exp_seq_pkg::*;
#(
  parameter int         EXP_WIDTH = 9,
  parameter logic [2:0] BIAS_SEL  = 3'b110,
  parameter logic [2:0] I2F_SEL   = 3'b101,
  parameter logic [2:0] ONE_SEL   = 3'b011
) (
  input  logic                 clk_in,
  input  logic                 reset_n_in,
  exp_sequencer_if.slave       bus,
  output logic                 rfWriteEnableR0_out,
  output logic                 rfWriteEnableR1_out,
  output logic [EXP_WIDTH-1:0] rfWriteValueR0_out,
  output logic [EXP_WIDTH-1:0] rfWriteValueR1_out,
  output logic [2:0]           rfReadSelectA_out,
  output logic [2:0]           rfReadSelectB_out,
  input  logic [EXP_WIDTH-1:0] rfReadResultA_in,
  input  logic [EXP_WIDTH-1:0] rfReadResultB_in
);

  state_e               state_q, state_d;
  logic [2:0]           op_q;
  logic [EXP_WIDTH-1:0] a_q, b_q;
  logic                 err_q;
  logic [EXP_WIDTH-1:0] result_q;
  logic                 neg_q, zero_q;

  logic                 accept;
  logic                 alu_sub;
  logic                 last_step;
  logic [EXP_WIDTH-1:0] alu_res;

  assign accept = (state_q == ST_IDLE) && bus.start_in;

  exp_alu #(.EXP_WIDTH(EXP_WIDTH)) u_alu (
    .a_i   (rfReadResultA_in),
    .b_i   (rfReadResultB_in),
    .sub_i (alu_sub),
    .res_o (alu_res)
  );

  // State register.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // Next state plus microcode: read selects, ALU mode and write enables per step.
  always_comb begin
    state_d             = state_q;
    rfReadSelectA_out   = SEL_R0;
    rfReadSelectB_out   = SEL_R1;
    alu_sub             = 1'b0;
    rfWriteEnableR0_out = 1'b0;
    rfWriteEnableR1_out = 1'b0;
    rfWriteValueR0_out  = '0;
    rfWriteValueR1_out  = '0;
    last_step           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = op_legal(bus.op_in) ? ST_LOAD : ST_DONE;
      end
      ST_LOAD: begin
        rfWriteEnableR0_out = 1'b1;
        rfWriteEnableR1_out = 1'b1;
        rfWriteValueR0_out  = a_q;
        rfWriteValueR1_out  = b_q;
        state_d             = ST_S1;
      end
      ST_S1: begin
        rfWriteEnableR0_out = 1'b1;
        rfWriteValueR0_out  = alu_res;
        case (op_q)
          OP_DIV, OP_SUB: alu_sub = 1'b1;
          OP_INT2FP: begin
            rfReadSelectA_out = I2F_SEL;
            alu_sub           = 1'b1;
          end
          OP_INC:  rfReadSelectB_out = ONE_SEL;
          default: alu_sub = 1'b0;
        endcase
        if (op_two_step(op_q)) begin
          state_d = ST_S2;
        end else begin
          state_d   = ST_DONE;
          last_step = 1'b1;
        end
      end
      ST_S2: begin
        rfWriteEnableR0_out = 1'b1;
        rfWriteValueR0_out  = alu_res;
        rfReadSelectB_out   = BIAS_SEL;
        alu_sub             = (op_q == OP_MUL);
        state_d             = ST_DONE;
        last_step           = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the command at accept; operands are latched so upstream may change them after the handshake.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      op_q  <= OP_MUL;
      a_q   <= '0;
      b_q   <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      op_q  <= bus.op_in;
      a_q   <= bus.expA_in;
      b_q   <= bus.expB_in;
      err_q <= !op_legal(bus.op_in);
    end
  end

  // Register the final step's ALU value and its flags; held across illegal ops.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      result_q <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (last_step) begin
      result_q <= alu_res;
      neg_q    <= alu_res[EXP_WIDTH-1];
      zero_q   <= (alu_res == '0);
    end
  end

  assign bus.ready_out  = (state_q == ST_IDLE);
  assign bus.done_out   = (state_q == ST_DONE);
  assign bus.err_out    = (state_q == ST_DONE) && err_q;
  assign bus.result_out = result_q;
  assign bus.neg_out    = neg_q;
  assign bus.zero_out   = zero_q;

endmodule

// File: tb/tb_exp_sequencer.sv
// Directed bench for exp_sequencer with a behavioural exponent register file.
module tb_exp_sequencer;
  import exp_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rf_rst = 1'b1;
  always #5 clk = ~clk;

  exp_sequencer_if #(.EXP_WIDTH(9)) bus ();

  logic       we0, we1;
  logic [8:0] wv0, wv1, rdA, rdB;
  logic [2:0] selA, selB;

  exp_sequencer dut (
    .clk_in              (clk),
    .reset_n_in          (rst_n),
    .bus                 (bus),
    .rfWriteEnableR0_out (we0),
    .rfWriteEnableR1_out (we1),
    .rfWriteValueR0_out  (wv0),
    .rfWriteValueR1_out  (wv1),
    .rfReadSelectA_out   (selA),
    .rfReadSelectB_out   (selB),
    .rfReadResultA_in    (rdA),
    .rfReadResultB_in    (rdB)
  );

  // Exponent register file model: R0/R1 plus constants, combinational read.
  logic [8:0] r0, r1;
  always @(posedge clk) begin
    if (rf_rst) begin
      r0 <= 9'd0;
      r1 <= 9'd0;
    end else begin
      if (we0) r0 <= wv0;
      if (we1) r1 <= wv1;
    end
  end

  function automatic logic [8:0] rf_read(input logic [2:0] sel);
    case (sel)
      SEL_R0:    return r0;
      SEL_R1:    return r1;
      SEL_ZERO:  return 9'd0;
      SEL_ONE:   return 9'd1;
      SEL_RADIX: return 9'd2;
      SEL_I2F:   return 9'd158;
      SEL_BIAS:  return 9'd127;
      default:   return 9'd511;
    endcase
  endfunction

  assign rdA = rf_read(selA);
  assign rdB = rf_read(selB);

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [8:0] a;
    logic [8:0] b;
    logic [8:0] res;
    logic       neg;
    logic       zero;
    logic       err;
    int         dcyc;
  } vec_t;

  vec_t vt[10];

  // One command: cycle 0 ends with the accepting edge; samples taken on negedges.
  task automatic run_vec(input vec_t v, input int hold, input string tag);
    int done_c;
    int ndone;
    logic we_seen;
    done_c  = -1;
    ndone   = 0;
    we_seen = 1'b0;
    @(negedge clk);
    bus.start_in = 1'b1;
    bus.op_in    = v.op;
    bus.expA_in  = v.a;
    bus.expB_in  = v.b;
    chk({tag, " ready_before"}, 32'(bus.ready_out), 32'd1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (we0 || we1) we_seen = 1'b1;
      chk({tag, " ready"}, 32'(bus.ready_out), 32'(c > v.dcyc));
      if (c == 1 && !v.err) begin
        chk({tag, " load_we"}, {30'd0, we0, we1}, 32'd3);
        chk({tag, " load_r0"}, 32'(wv0), 32'(v.a));
        chk({tag, " load_r1"}, 32'(wv1), 32'(v.b));
      end
      if (c > 1 && we1) chk({tag, " r1_rewritten"}, 32'(we1), 32'd0);
      if (bus.done_out) begin
        ndone++;
        if (done_c < 0) done_c = c;
        chk({tag, " err"}, 32'(bus.err_out), 32'(v.err));
      end
      if (c >= hold) bus.start_in = 1'b0;
    end
    chk({tag, " done_cycle"}, 32'(done_c), 32'(v.dcyc));
    chk({tag, " done_count"}, 32'(ndone), 32'd1);
    chk({tag, " result"}, 32'(bus.result_out), 32'(v.res));
    chk({tag, " neg"}, 32'(bus.neg_out), 32'(v.neg));
    chk({tag, " zero"}, 32'(bus.zero_out), 32'(v.zero));
    if (v.err) chk({tag, " no_writes"}, 32'(we_seen), 32'd0);
  endtask

  initial begin
    bus.start_in = 1'b0;
    bus.op_in    = 3'b000;
    bus.expA_in  = 9'd0;
    bus.expB_in  = 9'd0;

    //          op      a       b       res     neg   zero  err   dcyc
    vt[0] = '{3'b000, 9'd130, 9'd125, 9'd128, 1'b0, 1'b0, 1'b0, 4};
    vt[1] = '{3'b001, 9'd130, 9'd125, 9'd132, 1'b0, 1'b0, 1'b0, 4};
    vt[2] = '{3'b011, 9'd77,  9'd5,   9'd153, 1'b0, 1'b0, 1'b0, 3};
    vt[3] = '{3'b010, 9'd3,   9'd5,   9'd510, 1'b1, 1'b0, 1'b0, 3};
    vt[4] = '{3'b110, 9'd1,   9'd2,   9'd510, 1'b1, 1'b0, 1'b1, 1};
    vt[5] = '{3'b100, 9'd511, 9'd9,   9'd0,   1'b0, 1'b1, 1'b0, 3};
    vt[6] = '{3'b111, 9'd4,   9'd4,   9'd0,   1'b0, 1'b1, 1'b1, 1};
    vt[7] = '{3'b000, 9'd200, 9'd100, 9'd173, 1'b0, 1'b0, 1'b0, 4};
    vt[8] = '{3'b001, 9'd10,  9'd200, 9'd449, 1'b1, 1'b0, 1'b0, 4};
    vt[9] = '{3'b101, 9'd7,   9'd7,   9'd449, 1'b1, 1'b0, 1'b1, 1};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst ready", 32'(bus.ready_out), 32'd1);
    chk("rst done_err", {30'd0, bus.done_out, bus.err_out}, 32'd0);
    chk("rst result", 32'(bus.result_out), 32'd0);
    chk("rst flags", {30'd0, bus.neg_out, bus.zero_out}, 32'd0);
    chk("rst we", {30'd0, we0, we1}, 32'd0);
    chk("rst wv", {14'd0, wv0, wv1}, 32'd0);
    chk("rst selA", 32'(selA), 32'd0);
    chk("rst selB", 32'(selB), 32'd1);
    rst_n  = 1'b1;
    rf_rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vt[i], 0, $sformatf("vec%0d", i));

    // start_in held high through a MUL: one accept, busy in cycles 1..4.
    run_vec(vt[0], 4, "hold_mul");
    @(negedge clk);
    chk("hold no_reaccept", 32'(bus.ready_out), 32'd1);

    // Reset during S1 of a DIV aborts without a done pulse.
    begin
      int nd;
      nd = 0;
      @(negedge clk);
      bus.start_in = 1'b1;
      bus.op_in    = 3'b001;
      bus.expA_in  = 9'd130;
      bus.expB_in  = 9'd125;
      @(negedge clk);
      bus.start_in = 1'b0;
      @(negedge clk);
      chk("abort in_s1", 32'(we0), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort ready", 32'(bus.ready_out), 32'd1);
      chk("abort done", 32'(bus.done_out), 32'd0);
      chk("abort we", {30'd0, we0, we1}, 32'd0);
      chk("abort result", 32'(bus.result_out), 32'd0);
      chk("abort flags", {30'd0, bus.neg_out, bus.zero_out}, 32'd0);
      chk("abort sel", {26'd0, selA, selB}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (bus.done_out) nd++;
      end
      chk("abort no_done", 32'(nd), 32'd0);
    end
    run_vec(vt[0], 0, "post_reset_mul");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
